// File: rtl/ieee754_seq_subtractor.sv
// Multi-cycle IEEE-754 single-precision subtractor (result = op_a - op_b).
// Align, add/subtract and bit-serial normalization are sequenced by an FSM; truncating.
module ieee754_seq_subtractor #(
    parameter int UNDERFLOW_EXP = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    localparam logic signed [9:0] UfExp  = 10'(UNDERFLOW_EXP);
    localparam logic signed [9:0] OvfExp = 10'sd255;

    typedef enum logic [2:0] {StIdle, StAlign, StSub, StNorm, StDone} state_e;

    state_e             state_q, state_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;       // subtrahend with its sign already flipped
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [23:0]        ml_q, ml_d;
    logic [23:0]        ms_q, ms_d;
    logic [24:0]        sum_q, sum_d;
    logic [31:0]        result_q, result_d;

    // Operand zero detection: exponent 0 flushes denormals to zero.
    logic a_zero, b_zero;
    assign a_zero = (op_a[30:23] == 8'h00);
    assign b_zero = (op_b[30:23] == 8'h00);

    // Alignment datapath; ties in magnitude select a.
    logic        a_ge_b;
    logic [7:0]  exp_l, exp_s, exp_diff;
    logic [22:0] man_l, man_s;
    logic [23:0] ms_shifted;
    assign a_ge_b     = (a_q[30:0] >= b_q[30:0]);
    assign exp_l      = a_ge_b ? a_q[30:23] : b_q[30:23];
    assign exp_s      = a_ge_b ? b_q[30:23] : a_q[30:23];
    assign man_l      = a_ge_b ? a_q[22:0]  : b_q[22:0];
    assign man_s      = a_ge_b ? b_q[22:0]  : a_q[22:0];
    assign exp_diff   = exp_l - exp_s;
    assign ms_shifted = (exp_diff >= 8'd24) ? 24'h0 : ({1'b1, man_s} >> exp_diff);

    // Magnitude sum; ML >= MS so the difference never goes negative.
    logic [24:0] sum_calc;
    assign sum_calc = (a_q[31] == b_q[31]) ? ({1'b0, ml_q} + {1'b0, ms_q})
                                           : ({1'b0, ml_q} - {1'b0, ms_q});

    // Final packing, folding in the single right shift of the carry case.
    logic signed [9:0] norm_exp;
    logic [22:0]       norm_man;
    logic [31:0]       packed_res;
    assign norm_exp = sum_q[24] ? (exp_q + 10'sd1) : exp_q;
    assign norm_man = sum_q[24] ? sum_q[23:1] : sum_q[22:0];

    always_comb begin
        if (norm_exp >= OvfExp) begin
            packed_res = {sign_q, 8'hFF, 23'h0};
        end else if (norm_exp <= UfExp) begin
            packed_res = {sign_q, 31'h0};
        end else begin
            packed_res = {sign_q, norm_exp[7:0], norm_man};
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        ml_d     = ml_q;
        ms_d     = ms_q;
        sum_d    = sum_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d = op_a;
                    b_d = {~op_b[31], op_b[30:0]};
                    if (a_zero || b_zero) begin
                        state_d = StDone;
                        if (a_zero && b_zero) begin
                            result_d = 32'h0;
                        end else if (a_zero) begin
                            result_d = {~op_b[31], op_b[30:0]};
                        end else begin
                            result_d = op_a;
                        end
                    end else begin
                        state_d = StAlign;
                    end
                end
            end
            StAlign: begin
                sign_d  = a_ge_b ? a_q[31] : b_q[31];
                exp_d   = {2'b00, exp_l};
                ml_d    = {1'b1, man_l};
                ms_d    = ms_shifted;
                state_d = StSub;
            end
            StSub: begin
                sum_d   = sum_calc;
                state_d = StNorm;
            end
            StNorm: begin
                if (sum_q == 25'h0) begin
                    result_d = 32'h0;
                    state_d  = StDone;
                end else if (sum_q[24] || sum_q[23]) begin
                    result_d = packed_res;
                    state_d  = StDone;
                end else begin
                    sum_d = {sum_q[23:0], 1'b0};
                    exp_d = exp_q - 10'sd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            sign_q   <= 1'b0;
            exp_q    <= 10'sd0;
            ml_q     <= 24'h0;
            ms_q     <= 24'h0;
            sum_q    <= 25'h0;
            result_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            ml_q     <= ml_d;
            ms_q     <= ms_d;
            sum_q    <= sum_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;

endmodule

// File: tb/tb_ieee754_seq_subtractor.sv
// Randomized bench for ieee754_seq_subtractor against an arithmetic reference model,
// with literal expectations pinning the model on the directed cases.
module tb_ieee754_seq_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_result = 32'h0;

    ieee754_seq_subtractor #(.UNDERFLOW_EXP(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference: real-number style magnitude arithmetic on integers, truncating.
    function automatic void model(input logic [31:0] a, input logic [31:0] b_in,
                                  output logic [31:0] res, output int lat);
        logic [31:0] b;
        int          ea, eb, el, es, d, msb, e;
        longint      mag_a, mag_b, ml, ms, s, norm;
        logic        sl, ss;
        logic [9:0]  ev;
        b     = {~b_in[31], b_in[30:0]};
        ea    = int'(a[30:23]);
        eb    = int'(b[30:23]);
        lat   = 3;
        res   = 32'h0;
        if (ea == 0 || eb == 0) begin
            lat = 0;  // DONE is entered on the accept edge itself
            if (ea == 0 && eb == 0) res = 32'h0;
            else if (ea == 0)       res = b;
            else                    res = a;
            return;
        end
        mag_a = longint'(ea) * 64'd8388608 + longint'(a[22:0]);
        mag_b = longint'(eb) * 64'd8388608 + longint'(b[22:0]);
        if (mag_a >= mag_b) begin
            el = ea; es = eb; sl = a[31]; ss = b[31];
            ml = 64'd8388608 + longint'(a[22:0]);
            ms = 64'd8388608 + longint'(b[22:0]);
        end else begin
            el = eb; es = ea; sl = b[31]; ss = a[31];
            ml = 64'd8388608 + longint'(b[22:0]);
            ms = 64'd8388608 + longint'(a[22:0]);
        end
        d  = el - es;
        ms = (d >= 24) ? 64'd0 : (ms >> d);
        s  = (sl == ss) ? ml + ms : ml - ms;
        if (s == 0) begin
            res = 32'h0;
            return;
        end
        msb = 0;
        for (int i = 0; i < 25; i++) if (s[i]) msb = i;
        e    = el + msb - 23;
        norm = (msb >= 23) ? (s >> (msb - 23)) : (s << (23 - msb));
        lat  = 3 + ((msb < 23) ? (23 - msb) : 0);
        ev   = 10'(e);
        if (e >= 255)     res = {sl, 8'hFF, 23'h0};
        else if (e <= 0)  res = {sl, 31'h0};
        else              res = {sl, ev[7:0], norm[22:0]};
    endfunction

    // Continuous compare against the model's expectation while a result is offered.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_vs_ready", {31'h0, busy}, {31'h0, ~in_ready});
            if (out_valid) begin
                check("result", result, exp_result);
                check("in_ready_in_done", {31'h0, in_ready}, 32'h0);
            end
        end
    end

    // Called at #1 after a posedge with the DUT idle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                         input bit use_pin, input logic [31:0] pin_res, input int pin_lat);
        logic [31:0] m_res;
        int          m_lat;
        int          n;
        model(a, b, m_res, m_lat);
        if (use_pin) begin
            check("model_result_pin", m_res, pin_res);
            check("model_latency_pin", 32'(m_lat), 32'(pin_lat));
        end
        exp_result = m_res;
        op_a       = a;
        op_b       = b;
        in_valid   = 1'b1;
        out_ready  = (hold == 0);
        @(posedge clk);
        #1;
        // Inputs presented while busy must be ignored.
        op_a = $urandom;
        op_b = $urandom;
        n    = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        check("latency", 32'(n), 32'(m_lat));
        check("result_at_valid", result, m_res);
        if (use_pin) check("result_pin", result, pin_res);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'h0, out_valid}, 32'h1);
            check("hold_result", result, m_res);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("valid_drop", {31'h0, out_valid}, 32'h0);
        check("back_to_idle", {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          mode;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = 32'h0;
        op_b      = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, 32'h0);
        check("reset_valid", {31'h0, out_valid}, 32'h0);
        check("reset_ready", {31'h0, in_ready}, 32'h1);
        check("reset_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op(32'h40400000, 32'h3F800000, 0, 1'b1, 32'h40000000, 3);
        do_op(32'h3F800000, 32'h3F400000, 0, 1'b1, 32'h3E800000, 5);
        do_op(32'h3FC00000, 32'hBFC00000, 0, 1'b1, 32'h40400000, 3);
        do_op(32'h40200000, 32'h40200000, 0, 1'b1, 32'h00000000, 3);
        do_op(32'h00000000, 32'h40A00000, 4, 1'b1, 32'hC0A00000, 0);
        do_op(32'h7F7FFFFF, 32'hFF7FFFFF, 0, 1'b1, 32'h7F800000, 3);
        do_op(32'h00800000, 32'h00C00000, 0, 1'b1, 32'h80000000, 4);
        do_op(32'h3F800000, 32'h00000000, 1, 1'b1, 32'h3F800000, 0);
        do_op(32'h3F800001, 32'h3F800000, 0, 1'b1, 32'h34000000, 26);

        // Asynchronous reset while normalizing abandons the operation.
        op_a     = 32'h3F800000;
        op_b     = 32'h3F400000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_in_norm", {31'h0, busy}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'h0, out_valid}, 32'h0);
        check("async_rst_result", result, 32'h0);
        check("async_rst_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(32'h40400000, 32'h3F800000, 0, 1'b1, 32'h40000000, 3);

        for (int k = 0; k < 250; k++) begin
            ra   = $urandom;
            rb   = $urandom;
            mode = int'($urandom_range(0, 4));
            if (mode == 1) begin
                rb = {1'($urandom), ra[30:0] ^ 31'($urandom_range(0, 255))};
            end else if (mode == 2) begin
                if ($urandom_range(0, 1) == 1) ra[30:23] = 8'h00;
                else                           rb[30:23] = 8'h00;
            end else if (mode == 3) begin
                rb[30:23] = ra[30:23] + 8'($urandom_range(0, 2));
            end else if (mode == 4) begin
                rb = {1'($urandom), ra[30:23], 23'($urandom) & 23'h7FFFF0};
                ra[22:0] = ra[22:0] & 23'h7FFFF0;
            end
            do_op(ra, rb, int'($urandom_range(0, 2)), 1'b0, 32'h0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
